// File: rtl/sc_game_progress_ctrl.sv
// Game progress controller: tracks lives and level, sequences play, death/level-up
// pauses and the end-of-game states from debounced-by-edge button/sensor inputs.
module sc_game_progress_ctrl #(
    parameter int unsigned INIT_LIVES  = 3,
    parameter int unsigned MAX_LIVES   = 7,
    parameter int unsigned LAST_LEVEL  = 5,
    parameter int unsigned HOLD_CYCLES = 8
) (
    input  logic       SC_STATEMACHINEGENERAL_CLOCK_50,
    input  logic       SC_STATEMACHINEGENERAL_RESET_InHigh,
    input  logic       start_InLow,
    input  logic       collision_InLow,
    input  logic       goal_InLow,
    output logic [2:0] lives_Out,
    output logic [2:0] level_Out,
    output logic       play_enable_Out,
    output logic       frog_respawn_OutLow,
    output logic       game_over_Out,
    output logic       game_win_Out,
    output logic [2:0] debug_state
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PLAY       = 3'd1,
        DEATH_HOLD = 3'd2,
        LEVEL_UP   = 3'd3,
        GAME_OVER  = 3'd4,
        WIN        = 3'd5
    } state_t;

    localparam logic [2:0] INIT_L    = 3'(INIT_LIVES);
    localparam logic [2:0] MAX_L     = 3'(MAX_LIVES);
    localparam logic [2:0] LAST_LVL  = 3'(LAST_LEVEL);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    logic       clk;
    logic       rst;
    logic [2:0] in_vec;
    logic [2:0] sample;
    logic [2:0] prev;
    logic [2:0] armed;
    logic       rst_done;
    logic [2:0] evt;
    logic       start_evt;
    logic       coll_evt;
    logic       goal_evt;

    state_t     state;
    logic [2:0] lives;
    logic [2:0] level;
    logic [7:0] hold_cnt;
    logic       respawn_n;

    assign clk    = SC_STATEMACHINEGENERAL_CLOCK_50;
    assign rst    = SC_STATEMACHINEGENERAL_RESET_InHigh;
    assign in_vec = {start_InLow, collision_InLow, goal_InLow};

    // An input is only armed once a genuine post-reset high has been sampled,
    // so a line held low across reset release cannot fake a falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample   <= 3'b111;
            prev     <= 3'b111;
            armed    <= 3'b000;
            rst_done <= 1'b0;
        end else begin
            sample   <= in_vec;
            prev     <= sample;
            armed    <= armed | (sample & {3{rst_done}});
            rst_done <= 1'b1;
        end
    end

    assign evt       = armed & prev & ~sample;
    assign start_evt = evt[2];
    assign coll_evt  = evt[1];
    assign goal_evt  = evt[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lives     <= INIT_L;
            level     <= 3'd0;
            hold_cnt  <= 8'd0;
            respawn_n <= 1'b1;
        end else begin
            respawn_n <= 1'b1;
            case (state)
                IDLE: begin
                    lives    <= INIT_L;
                    level    <= 3'd0;
                    hold_cnt <= 8'd0;
                    if (start_evt) begin
                        state     <= PLAY;
                        respawn_n <= 1'b0;
                    end
                end
                PLAY: begin
                    hold_cnt <= 8'd0;
                    // Collision wins over a simultaneous goal.
                    if (coll_evt) begin
                        if (lives <= 3'd1) begin
                            lives <= 3'd0;
                            state <= GAME_OVER;
                        end else begin
                            lives <= lives - 3'd1;
                            state <= DEATH_HOLD;
                        end
                    end else if (goal_evt) begin
                        level <= level + 3'd1;
                        if (lives < MAX_L) begin
                            lives <= lives + 3'd1;
                        end
                        if (level + 3'd1 == LAST_LVL) begin
                            state <= WIN;
                        end else begin
                            state <= LEVEL_UP;
                        end
                    end
                end
                DEATH_HOLD, LEVEL_UP: begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt  <= 8'd0;
                        state     <= PLAY;
                        respawn_n <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                GAME_OVER, WIN: begin
                    if (start_evt) begin
                        state <= IDLE;
                        lives <= INIT_L;
                        level <= 3'd0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    lives    <= INIT_L;
                    level    <= 3'd0;
                    hold_cnt <= 8'd0;
                end
            endcase
        end
    end

    assign lives_Out           = lives;
    assign level_Out           = level;
    assign play_enable_Out     = (state == PLAY);
    assign game_over_Out       = (state == GAME_OVER);
    assign game_win_Out        = (state == WIN);
    assign frog_respawn_OutLow = respawn_n;
    assign debug_state         = state;

endmodule

// File: doc/sc_game_progress_ctrl.md
SC_GAME_PROGRESS_CTRL -- requirements
Module: sc_game_progress_ctrl

Interface
REQ-001 Parameter INIT_LIVES, 3, lives loaded at reset and on every new game.
REQ-002 Parameter MAX_LIVES, 7, saturation ceiling for the lives counter.
REQ-003 Parameter LAST_LEVEL, 5, level value at which the game is won.
REQ-004 Parameter HOLD_CYCLES, 8, pause length in clocks after a death or level-up (range 1..255).
REQ-005 SC_STATEMACHINEGENERAL_CLOCK_50  in  1  system clock; all state changes occur on its rising edge.
REQ-006 SC_STATEMACHINEGENERAL_RESET_InHigh  in  1  reset, asynchronous, active-high.
REQ-007 start_InLow  in  1  start button, active-low, level input.
REQ-008 collision_InLow  in  1  frog hit or drowned, active-low, level input.
REQ-009 goal_InLow  in  1  frog reached the top row, active-low, level input.
REQ-010 lives_Out  out  3  current lives count.
REQ-011 level_Out  out  3  current level, 0-based.
REQ-012 play_enable_Out  out  1  high only in state PLAY; gates the lanes and frog movement.
REQ-013 frog_respawn_OutLow  out  1  one-cycle active-low pulse that returns the frog to its start position.
REQ-014 game_over_Out  out  1  high only in state GAME_OVER.
REQ-015 game_win_Out  out  1  high only in state WIN.

Function
REQ-016 Each input SHALL be registered once per clock into a sample flop, with a second flop holding the previous sample; an event SHALL be previous=1 and current=0 (falling edge) and SHALL be valid for exactly one cycle.
REQ-017 State, counter and output updates SHALL occur on the clock edge after the event cycle (1-cycle latency from sampled edge).
REQ-018 States SHALL be IDLE, PLAY, DEATH_HOLD, LEVEL_UP, GAME_OVER and WIN, in a 3-bit register; unused encodings SHALL go to IDLE on the next clock.
REQ-019 IDLE: lives=INIT_LIVES and level=0 are held; a start event SHALL go to PLAY.
REQ-020 PLAY, collision event: lives SHALL decrement by 1; if lives was 1, the next state SHALL be GAME_OVER (lives=0), otherwise DEATH_HOLD.
REQ-021 PLAY, goal event without a collision event: level SHALL increment by 1 and lives SHALL increment by 1, saturating at MAX_LIVES; if the new level equals LAST_LEVEL, the next state SHALL be WIN, otherwise LEVEL_UP.
REQ-022 Simultaneous collision and goal events in PLAY: only the collision SHALL be processed; the level SHALL be unchanged.
REQ-023 Start events SHALL be ignored in PLAY, DEATH_HOLD and LEVEL_UP.
REQ-024 DEATH_HOLD and LEVEL_UP: an 8-bit hold counter SHALL be cleared on entry and SHALL return the state to PLAY after exactly HOLD_CYCLES cycles; collision and goal events SHALL be ignored during the hold.
REQ-025 frog_respawn_OutLow SHALL be low for exactly the first cycle of PLAY after entry from IDLE, DEATH_HOLD or LEVEL_UP, and high at all other times.
REQ-026 GAME_OVER and WIN: lives and level SHALL be frozen; a start event SHALL go to IDLE and reload lives=INIT_LIVES and level=0 on the same edge.
REQ-027 Lives SHALL never wrap below 0 or above MAX_LIVES; level SHALL never exceed LAST_LEVEL.
REQ-028 play_enable_Out, game_over_Out and game_win_Out SHALL be decoded from the state register only, with no combinational path from the inputs.

Reset
REQ-029 Reset assertion SHALL, asynchronously and at any point including mid-hold, force: state=IDLE, lives_Out=INIT_LIVES, level_Out=0, hold counter=0, all sample flops=1, play_enable_Out=0, frog_respawn_OutLow=1, game_over_Out=0, game_win_Out=0.
REQ-030 After reset deassertion, an input that is already held low SHALL NOT produce an event until it returns high and falls again.

Verification
REQ-031 Reset, then start falling edge -> PLAY two clocks later, one-cycle respawn low pulse, play_enable_Out=1, lives_Out=3, level_Out=0.
REQ-032 In PLAY, 3 collisions each separated by more than HOLD_CYCLES -> lives_Out 2, 1, 0, with DEATH_HOLD lasting exactly 8 clocks; after the third collision game_over_Out=1 and play_enable_Out=0.
REQ-033 In PLAY, 5 goal events -> level_Out 1..5, lives_Out 4..7 with saturation at 7, and game_win_Out=1 after the fifth goal.
REQ-034 Collision and goal falling in the same cycle with lives_Out=2 -> lives_Out=1, level_Out unchanged, state DEATH_HOLD.
REQ-035 Reset asserted during LEVEL_UP (hold count 4) -> immediate IDLE, lives_Out=3, level_Out=0; with start held low through deassertion -> state stays IDLE.
REQ-036 In GAME_OVER, a start event -> IDLE with lives_Out=3 and level_Out=0; a second start event -> PLAY with a respawn pulse.
